// File: rtl/dac_pkg.sv
// Shared constants and FSM state type for the DAC serial transmitter.
package dac_pkg;

    localparam int unsigned DAC_BITS   = 12;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dac_code_sat.sv
// Combinational sample-to-code converter: Q(p.f) signed sample -> 12-bit DAC code.
// Saturates below 0.0 and at/above 1.0; DAC_ROUND_EN adds half an LSB first.
module dac_code_sat
    import dac_pkg::*;
#(
    parameter int unsigned f     = 14,
    parameter int unsigned Width = 25
) (
    input  logic [Width-1:0]    dato_i,
    output logic [DAC_BITS-1:0] code_c
);

    // One extra bit so the rounding add can never wrap the sign.
    localparam int unsigned SW = Width + 1;

    logic [SW-1:0] val;

    // Sign-extend, optionally round, then clamp into [0, 0xFFF].
    always_comb begin
        val    = {dato_i[Width-1], dato_i};
`ifdef DAC_ROUND_EN
        val    = val + (SW'(1) << (f - 13));
`endif
        code_c = val[f-1:f-DAC_BITS];
        if (val[SW-1]) begin
            code_c = '0;
        end else if (|val[SW-2:f]) begin
            code_c = '1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one 16-bit frame {4'b0, code} per accepted sample strobe to a SPI DAC.
// Optional macro: DAC_ROUND_EN selects round-half-up conversion instead of truncation.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned p     = 10,
    parameter int unsigned f     = 14,
    parameter int unsigned Width = p + f + 1,
    parameter int unsigned DIV   = 2
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             enable,
    input  logic [Width-1:0] dato_dac,
    output logic             dac_sclk,
    output logic             dac_sync,
    output logic             dac_din,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HW = $clog2(2 * DIV);

    state_e                state_q, state_d;
    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic                  sclk_q, sclk_d;
    logic                  sync_q, sync_d;
    logic                  din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DAC_BITS-1:0]   code_c;
    logic [FRAME_BITS-1:0] frame_c;
    logic [HW-1:0]         hcnt_nxt_c;

    dac_code_sat #(
        .f     (f),
        .Width (Width)
    ) u_code_sat (
        .dato_i (dato_dac),
        .code_c (code_c)
    );

    assign frame_c    = {4'b0000, code_c};
    assign hcnt_nxt_c = hcnt_q + HW'(1);

    // State, counters, shift register and registered pin drivers.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state plus the pin values the next cycle must show (idle levels by default).
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sclk_d  = 1'b1;
        sync_d  = 1'b1;
        din_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT;
                    sh_d    = frame_c;
                    hcnt_d  = '0;
                    bit_d   = '0;
                    sync_d  = 1'b0;
                    din_d   = frame_c[FRAME_BITS-1];
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                sync_d = 1'b0;
                if (hcnt_q == HW'(2 * DIV - 1)) begin
                    hcnt_d = '0;
                    if (bit_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                        sync_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        // New bit starts on the dac_sclk rising edge.
                        bit_d = bit_q + BIT_CNT_W'(1);
                        sh_d  = sh_q << 1;
                        din_d = sh_q[FRAME_BITS-2];
                    end
                end else begin
                    hcnt_d = hcnt_nxt_c;
                    sclk_d = (32'(hcnt_nxt_c) < DIV);
                    din_d  = sh_q[FRAME_BITS-1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dac_sclk = sclk_q;
    assign dac_sync = sync_q;
    assign dac_din  = din_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: cycle-level reference model plus directed frames.
module tb_dac_spi_tx;

    localparam int unsigned P      = 10;
    localparam int unsigned F      = 14;
    localparam int unsigned W      = P + F + 1;
    localparam int unsigned DIV    = 2;
    localparam int          PERIOD = 32 * DIV;

`ifdef DAC_ROUND_EN
    localparam int SMALL_EXP = 16'h0001;
`else
    localparam int SMALL_EXP = 16'h0000;
`endif

    logic         sclk = 1'b0;
    logic         rst  = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] dato_dac = '0;
    logic         dac_sclk, dac_sync, dac_din, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 sclk = ~sclk;

    dac_spi_tx #(.p(P), .f(F), .Width(W), .DIV(DIV)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .enable   (enable),
        .dato_dac (dato_dac),
        .dac_sclk (dac_sclk),
        .dac_sync (dac_sync),
        .dac_din  (dac_din),
        .busy     (busy),
        .done     (done)
    );

    // Reference conversion from plain arithmetic on the sample value.
    function automatic logic [15:0] exp_frame(input logic [W-1:0] d);
        longint v;
        v = longint'($signed(d));
`ifdef DAC_ROUND_EN
        v = v + (longint'(1) << (F - 13));
`endif
        if (v < 0) return 16'h0000;
        v = v >>> (F - 12);
        if (v > 4095) v = 4095;
        return 16'(v);
    endfunction

    // Model: k = 0 idle, 1..PERIOD shifting, PERIOD+1 the done cycle.
    int          k = 0;
    logic [15:0] frame_m = '0;
    always @(posedge sclk or negedge rst) begin
        if (!rst)                k = 0;
        else if (k == PERIOD + 1) k = 0;
        else if (k == 0) begin
            if (enable) begin
                k = 1;
                frame_m = exp_frame(dato_dac);
            end
        end else k = k + 1;
    end

    // Compare every output against the model each cycle.
    always @(negedge sclk) begin
        logic [4:0] expv, gotv;
        int bi, ph;
        if (k == 0) expv = 5'b11000;
        else if (k == PERIOD + 1) expv = 5'b11011;
        else begin
            bi = (k - 1) / (2 * DIV);
            ph = (k - 1) % (2 * DIV);
            expv = {(ph < int'(DIV)), 1'b0, frame_m[15-bi], 1'b1, 1'b0};
        end
        gotv = {dac_sclk, dac_sync, dac_din, busy, done};
        tests++;
        if (gotv !== expv) begin
            fails++;
            $display("FAIL cycle_model t=%0t k=%0d got(sclk,sync,din,busy,done)=%b exp=%b",
                     $time, k, gotv, expv);
        end
    end

    // Receiver side: shift din on dac_sclk falling edges inside a frame, count done pulses.
    logic [15:0] rx = '0;
    int          edges = 0;
    int          ndone = 0;
    logic        prev_sync = 1'b1, prev_sclk = 1'b1;
    always @(negedge sclk) begin
        if (prev_sync && !dac_sync) begin
            rx    = '0;
            edges = 0;
        end else if (!dac_sync && prev_sclk && !dac_sclk) begin
            rx    = {rx[14:0], dac_din};
            edges = edges + 1;
        end
        if (done) ndone = ndone + 1;
        prev_sync = dac_sync;
        prev_sclk = dac_sclk;
    end

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, expv);
        end
    endtask

    // One sample strobe; optional stray enable at cycle extra_at; checks frame and timing.
    task automatic send(input logic [W-1:0] d, input int exp_f, input int extra_at);
        int  n, d0;
        bit  seen;
        @(negedge sclk);
        #1;
        d0 = ndone;
        dato_dac = d;
        enable   = 1'b1;
        seen     = 1'b0;
        n        = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sclk);
            enable = (i == extra_at);
            if (done) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("done_cycle", n, 65);
        #1;
        chk("rx_frame", int'(rx), exp_f);
        chk("model_frame", int'(frame_m), exp_f);
        chk("fall_edges", edges, 16);
        repeat (PERIOD + 8) @(negedge sclk);
        #1;
        chk("one_done", ndone - d0, 1);
    endtask

    initial begin
        int d0, gap, t1, t2, t3, nd;
        bit gap_end;

        #1 rst = 1'b0;
        #1;
        chk("rst_outputs", int'({dac_sclk, dac_sync, dac_din, busy, done}), 5'b11000);
        repeat (3) @(negedge sclk);
        rst = 1'b1;

        send(25'h0002000, 16'h0800, 0);
        send('1,          16'h0000, 0);
        send(25'h0004000, 16'h0FFF, 0);
        send(25'h07FFFFF, 16'h0FFF, 0);
        send(25'h0001234, 16'h048D, 0);
        send(25'h0000002, SMALL_EXP, 0);
        send(25'h0003FFF, 16'h0FFF, 0);
        send(25'h0002000, 16'h0800, 20);

        // Mid-frame reset: pins go idle immediately, no done pulse.
        @(negedge sclk);
        #1;
        d0 = ndone;
        dato_dac = 25'h0002000;
        enable   = 1'b1;
        @(negedge sclk);
        enable = 1'b0;
        repeat (29) @(negedge sclk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sync", int'(dac_sync), 1);
        chk("async_rst_sclk", int'(dac_sclk), 1);
        chk("async_rst_busy", int'(busy), 0);
        repeat (5) @(negedge sclk);
        rst = 1'b1;
        repeat (PERIOD + 8) @(negedge sclk);
        #1;
        chk("abort_no_done", ndone - d0, 0);
        send(25'h0002000, 16'h0800, 0);

        // Enable held high: back-to-back frames.
        @(negedge sclk);
        dato_dac = 25'h0002000;
        enable   = 1'b1;
        nd = 0; gap = 0; gap_end = 1'b0; t1 = 0; t2 = 0; t3 = 0;
        for (int i = 1; i <= 400 && nd < 3; i++) begin
            @(negedge sclk);
            if (done) begin
                nd++;
                if (nd == 1) t1 = i;
                if (nd == 2) t2 = i;
                if (nd == 3) t3 = i;
            end
            if (nd == 1 && !gap_end) begin
                if (dac_sync) gap++;
                else gap_end = 1'b1;
            end
        end
        enable = 1'b0;
        chk("b2b_dones", nd, 3);
        chk("b2b_first", t1, 65);
        chk("b2b_spacing1", t2 - t1, 66);
        chk("b2b_spacing2", t3 - t2, 66);
        chk("b2b_sync_gap_ge2", int'(gap >= 2), 1);
        #1;
        chk("b2b_frame", int'(rx), 16'h0800);
        repeat (PERIOD + 8) @(negedge sclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
